// File: rtl/launch_arbiter.sv
// launch_arbiter: round-robin owner of a shared enable-gated launch register.
// Each grant drives launch_en and the winner's data for one cycle, then the
// launched value is held for HOLD_CYCLES before the next arbitration.
module launch_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       launch_en,
  output logic [DATA_W-1:0]          launch_d,
  output logic [$clog2(NUM_REQ)-1:0] launch_owner,
  output logic                       busy,
  output logic [CNT_W-1:0]           launch_count
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  // hold counter needs at least one bit even when HOLD_CYCLES is 1
  localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCNT_W-1:0] HOLD_INIT = HCNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [HCNT_W-1:0]   hold_cnt, hold_nxt;
  logic                en_nxt;
  logic [NUM_REQ-1:0]  ready_nxt;
  logic [DATA_W-1:0]   d_nxt;
  logic [PTR_W-1:0]    owner_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic                found;
  logic [PTR_W-1:0]    win;

  // Scan last+1, last+2, ... (mod NUM_REQ) and return {found, index} of the
  // first valid requester; the last winner is therefore checked last.
  function automatic logic [PTR_W:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   last);
    logic             hit;
    logic [PTR_W-1:0] sel;
    int               idx;
    hit = 1'b0;
    sel = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!hit && valid[idx]) begin
        hit = 1'b1;
        sel = PTR_W'(idx);
      end
    end
    return {hit, sel};
  endfunction

  assign {found, win} = pick_winner(req_valid, ptr);

  // Next-state and next-output decode; every register holds unless a state acts.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    en_nxt    = 1'b0;
    ready_nxt = '0;
    d_nxt     = launch_d;
    owner_nxt = launch_owner;
    count_nxt = launch_count;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = LAUNCH;
          ptr_nxt        = win;
          owner_nxt      = win;
          d_nxt          = req_data[win*DATA_W +: DATA_W];
          en_nxt         = 1'b1;
          ready_nxt[win] = 1'b1;
        end
      end
      LAUNCH: begin
        // downstream flop captures launch_d at the end of this cycle
        state_nxt = HOLD;
        hold_nxt  = HOLD_INIT;
        count_nxt = launch_count + CNT_W'(1);
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt - HCNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset cuts any in-flight pulse immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= PTR_W'(NUM_REQ - 1);
      hold_cnt     <= '0;
      launch_en    <= 1'b0;
      req_ready    <= '0;
      launch_d     <= '0;
      launch_owner <= '0;
      launch_count <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      hold_cnt     <= hold_nxt;
      launch_en    <= en_nxt;
      req_ready    <= ready_nxt;
      launch_d     <= d_nxt;
      launch_owner <= owner_nxt;
      launch_count <= count_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_launch_arbiter.sv
// tb_launch_arbiter: directed scenarios plus randomized requesters, every
// cycle compared against a cycle-count reference model of the arbiter.
module tb_launch_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int H  = 2;
  localparam int CW = 8;
  localparam int OW = $clog2(N);

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              launch_en;
  logic [DW-1:0]     launch_d;
  logic [OW-1:0]     launch_owner;
  logic              busy;
  logic [CW-1:0]     launch_count;

  launch_arbiter #(.NUM_REQ(N), .DATA_W(DW), .HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .launch_en    (launch_en),
    .launch_d     (launch_d),
    .launch_owner (launch_owner),
    .busy         (busy),
    .launch_count (launch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: busy cycles remaining rather than an FSM
  int           m_busy_left;
  int           m_ptr;
  logic         m_en;
  logic [N-1:0] m_ready;
  logic [DW-1:0] m_d;
  int           m_owner;
  int           m_count;
  logic [N-1:0] m_granted;

  logic [N-1:0] done_ready;
  int           cyc = 0;
  int           waits [N];
  int           max_wait = 0;
  int           prev_cnt = 0;
  bit           wrap_seen = 0;
  int           g_owner[$];
  int           g_cyc[$];
  int           g_d[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy_left = 0;
    m_ptr       = N - 1;
    m_en        = 1'b0;
    m_ready     = '0;
    m_d         = '0;
    m_owner     = 0;
    m_count     = 0;
    m_granted   = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
  endtask

  task automatic model_edge();
    m_granted = '0;
    if (m_busy_left == 0) begin
      if (req_valid != '0) begin
        int w;
        w = -1;
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (w < 0 && req_valid[idx]) w = idx;
        end
        m_d          = req_data[w*DW +: DW];
        m_owner      = w;
        m_ptr        = w;
        m_en         = 1'b1;
        m_ready      = '0;
        m_ready[w]   = 1'b1;
        m_granted[w] = 1'b1;
        m_busy_left  = H + 1;
      end
    end else begin
      m_busy_left--;
      if (m_en) begin
        m_en    = 1'b0;
        m_ready = '0;
        m_count = (m_count + 1) % (1 << CW);
      end
    end
  endtask

  task automatic check_outputs();
    check("launch_en", launch_en, m_en);
    check("req_ready", req_ready, m_ready);
    check("launch_d", launch_d, m_d);
    check("owner", launch_owner, m_owner);
    check("busy", busy, m_busy_left > 0);
    check("count", launch_count, m_count);
    if (launch_en) check("ready_onehot", $countones(req_ready), 1);
  endtask

  // one clock: model follows the edge, outputs compared 1 time unit later
  task automatic cycle();
    logic [N-1:0] prev;
    @(posedge clk);
    cyc++;
    prev = m_ready;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !prev[i]) waits[i]++;
      else waits[i] = 0;
      if (waits[i] > max_wait) max_wait = waits[i];
    end
    model_edge();
    for (int i = 0; i < N; i++) if (m_granted[i]) waits[i] = 0;
    #1;
    check_outputs();
    if (launch_en) begin
      g_owner.push_back(int'(launch_owner));
      g_cyc.push_back(cyc);
      g_d.push_back(int'(launch_d));
    end
    if (prev_cnt == 255 && launch_count == 8'd0) wrap_seen = 1;
    prev_cnt = int'(launch_count);
    done_ready = prev;
  endtask

  // protocol-abiding requesters: hold until ready, then drop or present new data
  task automatic update_reqs(input logic [N-1:0] allow, input int p_raise, input int p_drop);
    for (int i = 0; i < N; i++) begin
      if (done_ready[i]) begin
        if (!allow[i] || int'($urandom_range(99)) < p_drop) req_valid[i] = 1'b0;
        else req_data[i*DW +: DW] = DW'($urandom);
      end else if (!req_valid[i] && allow[i] && int'($urandom_range(99)) < p_raise) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic run(input int n, input logic [N-1:0] allow, input int p_raise, input int p_drop);
    for (int k = 0; k < n; k++) begin
      cycle();
      update_reqs(allow, p_raise, p_drop);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    done_ready = '0;
    model_reset();
    #1;
    check("rst_en", launch_en, 0);
    check("rst_ready", req_ready, 0);
    check("rst_d", launch_d, 0);
    check("rst_owner", launch_owner, 0);
    check("rst_busy", busy, 0);
    check("rst_count", launch_count, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // single request from requester 2 with data A
    req_valid = 4'b0100;
    req_data  = {4'h1, 4'hA, 4'h7, 4'h9};
    cycle();
    check("t2_ready", req_ready, 4'b0100);
    check("t2_en", launch_en, 1);
    check("t2_d", launch_d, 4'hA);
    check("t2_owner", launch_owner, 2);
    check("t2_busy_t1", busy, 1);
    cycle();
    update_reqs('0, 0, 100);
    check("t2_busy_t2", busy, 1);
    cycle();
    check("t2_busy_t3", busy, 1);
    cycle();
    check("t2_idle_t4", busy, 0);
    check("t2_count", launch_count, 1);

    // last owner 2, requesters 3 and 1 together: 3 first, then 1 with data 5
    g_owner.delete(); g_cyc.delete(); g_d.delete();
    req_valid = 4'b1010;
    req_data  = {4'hC, 4'h0, 4'h5, 4'h0};
    run(12, '0, 0, 100);
    check("t4_n_grants", g_owner.size(), 2);
    if (g_owner.size() >= 2) begin
      check("t4_first", g_owner[0], 3);
      check("t4_second", g_owner[1], 1);
      check("t4_d1", g_d[1], 4'h5);
    end

    // launch of 3, then 20 idle cycles with outputs held
    req_valid = 4'b0001;
    req_data  = {4'h0, 4'h0, 4'h0, 4'h3};
    run(24, '0, 0, 100);
    check("t6_d", launch_d, 4'h3);
    check("t6_owner", launch_owner, 0);
    check("t6_busy", busy, 0);
    check("t6_en", launch_en, 0);

    // asynchronous reset in the middle of HOLD
    req_valid = 4'b0010;
    req_data  = {4'h0, 4'h0, 4'hE, 4'h0};
    cycle();
    cycle();
    update_reqs('0, 0, 100);
    #3;
    reset = 1'b1;
    #1;
    check("t1_en", launch_en, 0);
    check("t1_ready", req_ready, 0);
    check("t1_owner", launch_owner, 0);
    check("t1_count", launch_count, 0);
    check("t1_busy", busy, 0);
    check("t1_d", launch_d, 0);
    model_reset();
    prev_cnt  = 0;
    req_valid = 4'b1111;
    req_data  = {4'h4, 4'h3, 4'h2, 4'h1};
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // everyone continuously valid: strict rotation 0,1,2,3,0,1 four cycles apart
    g_owner.delete(); g_cyc.delete(); g_d.delete();
    cycle();
    check("t1_winner", launch_owner, 0);
    check("t1_winner_ready", req_ready, 4'b0001);
    run(24, 4'b1111, 100, 0);
    check("t3_n_grants", g_owner.size() >= 6, 1);
    if (g_owner.size() >= 6) begin
      for (int k = 0; k < 6; k++) check($sformatf("t3_order%0d", k), g_owner[k], k % N);
      for (int k = 0; k < 5; k++) check($sformatf("t3_gap%0d", k), g_cyc[k+1] - g_cyc[k], H + 2);
    end

    // one requester back to back until the counter wraps
    run(1100, 4'b0100, 100, 0);
    check("t5_wrap", wrap_seen, 1);

    // randomized traffic
    run(3000, 4'b1111, 30, 50);
    run(40, '0, 0, 100);
    check("starve_bound", max_wait <= N * (H + 2) + 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
